// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forward codes,
// divider FSM states and the per-stage destination-tracking record.
package pipe_pkg;

  // Slot register fields are stored at this width; narrower REG_AW values zero-extend.
  localparam int unsigned RegAwMax = 8;

  typedef logic [RegAwMax-1:0] reg_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    DivIdle,
    DivBusy,
    DivDone
  } div_state_e;

  typedef struct packed {
    logic valid;
    reg_t rs;
    reg_t rt;
    logic use_rs;
    logic use_rt;
    reg_t dst;
    logic regwrite;
    logic load;
  } slot_t;

  // MEM wins over WB; a load in MEM has no ALU result yet, so it falls through to WB.
  function automatic fwd_e fwd_select(input logic use_op, input reg_t op,
                                      input slot_t mem, input slot_t wb);
    fwd_e sel;
    sel = FWD_RF;
    if (use_op) begin
      if (mem.valid && mem.regwrite && !mem.load && (mem.dst != '0) && (mem.dst == op)) begin
        sel = FWD_MEM;
      end else if (wb.valid && wb.regwrite && (wb.dst != '0) && (wb.dst == op)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/div_stall_fsm.sv
// Multi-cycle divider sequencer: freezes the front of the pipeline while the
// divide runs, then strobes done for one cycle.
module div_stall_fsm
  import pipe_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic freeze_o
);

  localparam logic [7:0] CntLoad = 8'(DIV_CYCLES - 2);

  div_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DivIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DivIdle: begin
        if (start_i) begin
          state_d = DivBusy;
          cnt_d   = CntLoad;
        end
      end
      DivBusy: begin
        if (cnt_q == '0) begin
          state_d = DivDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DivDone: begin
        // A div queued right behind the finishing one restarts without an idle cycle.
        if (start_i) begin
          state_d = DivBusy;
          cnt_d   = CntLoad;
        end else begin
          state_d = DivIdle;
        end
      end
      default: state_d = DivIdle;
    endcase
  end

  always_comb begin
    busy_o   = (state_q == DivBusy);
    done_o   = (state_q == DivDone);
    freeze_o = (state_q == DivBusy);
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks EX/MEM/WB
// destinations, drives the EX operand mux selects and generates stalls/bubbles.
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_load,
  input  logic              id_div,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              flush_ex,
  output logic              div_busy,
  output logic              div_done
);

  slot_t id_slot;
  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;
  logic  freeze;
  logic  load_use;
  logic  div_start;

  always_comb begin
    id_slot = '0;
    if (id_valid) begin
      id_slot.valid    = 1'b1;
      id_slot.rs       = reg_t'(id_rs);
      id_slot.rt       = reg_t'(id_rt);
      id_slot.use_rs   = id_use_rs;
      id_slot.use_rt   = id_use_rt;
      id_slot.dst      = reg_t'(id_dst);
      id_slot.regwrite = id_regwrite;
      id_slot.load     = id_load;
    end
  end

  always_comb begin
    load_use = ex_q.valid && ex_q.load && (ex_q.dst != '0) && id_slot.valid &&
               ((id_slot.use_rs && (id_slot.rs == ex_q.dst)) ||
                (id_slot.use_rt && (id_slot.rt == ex_q.dst)));
    // The divider freeze masks load-use: the EX slot is held, not bubbled.
    stall_ex  = freeze;
    flush_ex  = load_use && !freeze;
    stall_if  = freeze || flush_ex;
    stall_id  = freeze || flush_ex;
    div_start = id_valid && id_div && !stall_ex && !flush_ex;
  end

  always_comb begin
    if (flush_ex) begin
      ex_d = '0;
    end else if (stall_ex) begin
      ex_d = ex_q;
    end else begin
      ex_d = id_slot;
    end
    mem_d = stall_ex ? '0 : ex_q;
    wb_d  = mem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  always_comb begin
    fwd_a_sel = fwd_select(ex_q.use_rs, ex_q.rs, mem_q, wb_q);
    fwd_b_sel = fwd_select(ex_q.use_rt, ex_q.rt, mem_q, wb_q);
  end

  div_stall_fsm #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_stall_fsm (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .freeze_o(freeze)
  );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: instruction-level pipeline model checked every
// cycle, directed hazard scenarios with literal expectations, then random traffic.
module tb_fwd_hazard_unit;

  localparam int unsigned RegAw     = 5;
  localparam int unsigned DivCycles = 4;

  typedef struct {
    bit v;
    int rs;
    int rt;
    bit urs;
    bit urt;
    int dst;
    bit we;
    bit ld;
    bit dv;
  } instr_t;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [RegAw-1:0]  id_rs;
  logic [RegAw-1:0]  id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [RegAw-1:0]  id_dst;
  logic              id_regwrite;
  logic              id_load;
  logic              id_div;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall_if;
  logic              stall_id;
  logic              stall_ex;
  logic              flush_ex;
  logic              div_busy;
  logic              div_done;

  fwd_hazard_unit #(
    .REG_AW    (RegAw),
    .DIV_CYCLES(DivCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .id_dst     (id_dst),
    .id_regwrite(id_regwrite),
    .id_load    (id_load),
    .id_div     (id_div),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .stall_if   (stall_if),
    .stall_id   (stall_id),
    .stall_ex   (stall_ex),
    .flush_ex   (flush_ex),
    .div_busy   (div_busy),
    .div_done   (div_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: which instruction occupies each stage, and how many freeze cycles remain.
  instr_t m_ex, m_mem, m_wb, cur;
  int     div_left;
  bit     done_now;
  logic [1:0] e_a, e_b;
  logic   e_sif, e_sid, e_sex, e_flush, e_busy, e_done;

  function automatic instr_t nop();
    instr_t i;
    i = '{default: 0};
    return i;
  endfunction

  function automatic instr_t mk(int rs, int rt, bit urs, bit urt, int dst, bit we, bit ld, bit dv);
    instr_t i;
    i = '{v: 1, rs: rs, rt: rt, urs: urs, urt: urt, dst: dst, we: we, ld: ld, dv: dv};
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    i = nop();
    i.rs  = int'($urandom_range(7));
    i.rt  = int'($urandom_range(7));
    i.dst = int'($urandom_range(7));
    if ($urandom_range(99) < 15) return i;
    i.v   = 1'b1;
    i.urs = 1'($urandom_range(1));
    i.urt = 1'($urandom_range(1));
    k = int'($urandom_range(99));
    if (k < 25) begin
      i.ld = 1'b1;
      i.we = 1'b1;
    end else if (k < 30) begin
      i.dv = 1'b1;
    end else begin
      i.we = ($urandom_range(9) != 0);
    end
    return i;
  endfunction

  function automatic logic [1:0] model_sel(bit use_op, int r);
    if (!m_ex.v || !use_op || r == 0) return 2'b00;
    if (m_mem.v && m_mem.we && !m_mem.ld && m_mem.dst == r) return 2'b10;
    if (m_wb.v && m_wb.we && m_wb.dst == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ex     = nop();
    m_mem    = nop();
    m_wb     = nop();
    div_left = 0;
    done_now = 1'b0;
  endtask

  task automatic model_eval();
    bit freeze;
    freeze  = (div_left > 0);
    e_flush = !freeze && m_ex.v && m_ex.ld && m_ex.dst != 0 && cur.v &&
              ((cur.urs && cur.rs == m_ex.dst) || (cur.urt && cur.rt == m_ex.dst));
    e_sex   = freeze;
    e_sif   = freeze || e_flush;
    e_sid   = freeze || e_flush;
    e_busy  = freeze;
    e_done  = done_now;
    e_a     = model_sel(m_ex.urs, m_ex.rs);
    e_b     = model_sel(m_ex.urt, m_ex.rt);
  endtask

  task automatic model_step();
    if (div_left > 0) begin
      div_left--;
      m_wb  = m_mem;
      m_mem = nop();
      if (div_left == 0) done_now = 1'b1;
    end else begin
      done_now = 1'b0;
      m_wb  = m_mem;
      m_mem = m_ex;
      if (e_flush || !cur.v) begin
        m_ex = nop();
      end else begin
        m_ex = cur;
        if (cur.dv) div_left = DivCycles - 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e_a));
    chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e_b));
    chk("stall_if", 32'(stall_if), 32'(e_sif));
    chk("stall_id", 32'(stall_id), 32'(e_sid));
    chk("stall_ex", 32'(stall_ex), 32'(e_sex));
    chk("flush_ex", 32'(flush_ex), 32'(e_flush));
    chk("div_busy", 32'(div_busy), 32'(e_busy));
    chk("div_done", 32'(div_done), 32'(e_done));
  endtask

  // Called just after a rising edge; compares mid-cycle.
  task automatic present(input instr_t in);
    cur         = in;
    id_valid    = in.v;
    id_rs       = RegAw'(in.rs);
    id_rt       = RegAw'(in.rt);
    id_use_rs   = in.urs;
    id_use_rt   = in.urt;
    id_dst      = RegAw'(in.dst);
    id_regwrite = in.we;
    id_load     = in.ld;
    id_div      = in.dv;
    model_eval();
    #3;
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    repeat (8) begin
      present(nop());
      advance();
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " fwd_a_sel"}, 32'(fwd_a_sel), 32'd0);
    chk({tag, " fwd_b_sel"}, 32'(fwd_b_sel), 32'd0);
    chk({tag, " stall_if"}, 32'(stall_if), 32'd0);
    chk({tag, " stall_id"}, 32'(stall_id), 32'd0);
    chk({tag, " stall_ex"}, 32'(stall_ex), 32'd0);
    chk({tag, " flush_ex"}, 32'(flush_ex), 32'd0);
    chk({tag, " div_busy"}, 32'(div_busy), 32'd0);
    chk({tag, " div_done"}, 32'(div_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    instr_t ri;
    instr_t addi;
    bit     held;
    int     cnt;

    rst = 1'b0;
    model_reset();
    cur = nop();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_dst = '0; id_regwrite = 1'b0; id_load = 1'b0; id_div = 1'b0;
    #1 rst = 1'b1;
    #2 chk_idle_outputs("reset");
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back dependence: add $3 ; sub $4,$3,$5
    drain();
    present(mk(1, 2, 1, 1, 3, 1, 0, 0)); advance();
    present(mk(3, 5, 1, 1, 4, 1, 0, 0)); advance();
    present(nop());
    chk("b2b fwd_a", 32'(fwd_a_sel), 32'h2);
    chk("b2b fwd_b", 32'(fwd_b_sel), 32'h0);
    advance();

    // Gap of one: add $3 ; nop ; or $6,$3,$3
    drain();
    present(mk(1, 2, 1, 1, 3, 1, 0, 0)); advance();
    present(nop()); advance();
    present(mk(3, 3, 1, 1, 6, 1, 0, 0)); advance();
    present(nop());
    chk("gap fwd_a", 32'(fwd_a_sel), 32'h1);
    chk("gap fwd_b", 32'(fwd_b_sel), 32'h1);
    advance();

    // MEM beats WB for the same register; an unused operand stays on the register file.
    drain();
    present(mk(1, 2, 1, 1, 3, 1, 0, 0)); advance();
    present(mk(4, 5, 1, 1, 3, 1, 0, 0)); advance();
    present(mk(3, 3, 1, 0, 9, 1, 0, 0)); advance();
    present(nop());
    chk("prio fwd_a", 32'(fwd_a_sel), 32'h2);
    chk("prio unused fwd_b", 32'(fwd_b_sel), 32'h0);
    advance();

    // Register zero is never forwarded.
    drain();
    present(mk(1, 2, 1, 1, 0, 1, 0, 0)); advance();
    present(mk(0, 0, 1, 1, 5, 1, 0, 0)); advance();
    present(nop());
    chk("r0 fwd_a", 32'(fwd_a_sel), 32'h0);
    chk("r0 fwd_b", 32'(fwd_b_sel), 32'h0);
    advance();

    // Load-use: lw $2 ; add $7,$2,$1
    drain();
    present(mk(1, 0, 1, 0, 2, 1, 1, 0)); advance();
    addi = mk(2, 1, 1, 1, 7, 1, 0, 0);
    present(addi);
    chk("lu stall_if", 32'(stall_if), 32'h1);
    chk("lu stall_id", 32'(stall_id), 32'h1);
    chk("lu flush_ex", 32'(flush_ex), 32'h1);
    chk("lu stall_ex", 32'(stall_ex), 32'h0);
    advance();
    present(addi);
    chk("lu second stall_if", 32'(stall_if), 32'h0);
    chk("lu second flush_ex", 32'(flush_ex), 32'h0);
    advance();
    present(nop());
    chk("lu fwd_a", 32'(fwd_a_sel), 32'h1);
    chk("lu fwd_b", 32'(fwd_b_sel), 32'h0);
    advance();

    // Divider: lw $2 ; div $8,$9 ; dependent add waiting in ID during the freeze.
    drain();
    present(mk(1, 0, 1, 0, 2, 1, 1, 0)); advance();
    present(mk(8, 9, 1, 1, 0, 0, 0, 1)); advance();
    for (int k = 0; k < 3; k++) begin
      present(addi);
      chk("div busy", 32'(div_busy), 32'h1);
      chk("div stall_ex", 32'(stall_ex), 32'h1);
      chk("div stall_if", 32'(stall_if), 32'h1);
      chk("div no flush", 32'(flush_ex), 32'h0);
      chk("div not done", 32'(div_done), 32'h0);
      advance();
    end
    present(addi);
    chk("div done", 32'(div_done), 32'h1);
    chk("div done busy", 32'(div_busy), 32'h0);
    chk("div done stall_ex", 32'(stall_ex), 32'h0);
    chk("div done stall_if", 32'(stall_if), 32'h0);
    advance();
    present(nop());
    chk("div after done", 32'(div_done), 32'h0);
    advance();

    // Reset in the middle of a busy divide.
    drain();
    present(mk(1, 2, 1, 1, 8, 1, 0, 0)); advance();
    present(mk(8, 9, 1, 1, 0, 0, 0, 1)); advance();
    present(nop());
    chk("pre-reset busy", 32'(div_busy), 32'h1);
    chk("pre-reset fwd_a", 32'(fwd_a_sel), 32'h2);
    #1 rst = 1'b1;
    #1 chk_idle_outputs("mid-busy reset");
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    present(mk(8, 9, 1, 1, 0, 0, 0, 1)); advance();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      present(nop());
      if (div_busy !== 1'b1) break;
      cnt++;
      advance();
    end
    chk("post-reset busy cycles", 32'(cnt), 32'd3);
    chk("post-reset done", 32'(div_done), 32'h1);
    advance();

    // Random traffic; an instruction stays in ID while the model says ID is held.
    drain();
    ri = rand_instr();
    repeat (600) begin
      present(ri);
      held = e_sid;
      advance();
      if (!held) ri = rand_instr();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Central hazard and forwarding controller for the 5-stage MIPS pipeline.
- Tracks the destination-register state of the EX, MEM and WB stages internally.
- Drives the 2-bit select inputs of the EX-stage 4:1 operand multiplexers.
- Generates load-use stalls and holds the pipeline while the multi-cycle divider runs.

Parameters:
- REG_AW, 5: register-file address width.
- DIV_CYCLES, 32: divider busy cycles, counted from entry into EX until the result is ready; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- id_valid  in  1  ID slot holds a real instruction.
- id_rs  in  REG_AW  rs field of the ID instruction.
- id_rt  in  REG_AW  rt field of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_dst  in  REG_AW  destination register of the ID instruction.
- id_regwrite  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load.
- id_div  in  1  ID instruction is div/divu.
- fwd_a_sel  out  2  EX operand A mux select.
- fwd_b_sel  out  2  EX operand B mux select.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- stall_ex  out  1  hold ID/EX register.
- flush_ex  out  1  load a bubble into ID/EX.
- div_busy  out  1  divider FSM in BUSY.
- div_done  out  1  one-cycle HI/LO write strobe.

Behaviour:
- Internal tracking registers
  - Three slots: EX, MEM and WB. Each slot holds {valid, rs, rt, use_rs, use_rt, dst, regwrite, load}.
  - The EX slot loads the ID inputs, gated by id_valid, when stall_ex=0 and flush_ex=0.
  - On flush_ex=1 the EX slot becomes invalid (bubble).
  - The MEM slot loads the EX slot when stall_ex=0; otherwise it loads invalid.
  - The WB slot always loads the MEM slot.
  - On rst, every slot is invalid, the FSM is IDLE and the counter is 0.
- Forward selects
  - Combinational from the slot registers; no added latency.
  - Code 2'b10: EX/MEM ALU result. Used when the MEM slot is valid, has regwrite=1, is not a load, has dst!=0, and its dst equals the EX operand register.
  - Code 2'b01: MEM/WB result. Used when the WB slot is valid, has regwrite=1, has dst!=0, and its dst matches.
  - Code 2'b00: register file. Default in all other cases.
  - 2'b11 is never driven.
  - Priority: MEM over WB.
  - An operand whose use flag is 0 gets 2'b00.
  - Register 0 is never forwarded.
- Load-use hazard
  - Raised when the EX slot is valid with load=1 and dst!=0, id_valid=1, and (id_use_rs and id_rs==dst) or (id_use_rt and id_rt==dst).
  - Response: stall_if=1, stall_id=1, flush_ex=1 for exactly one cycle.
  - The next cycle resolves through the WB forward.
- Divider FSM: IDLE -> BUSY -> DONE -> IDLE.
  - IDLE -> BUSY on the clock edge that loads an EX slot with div=1. The counter loads DIV_CYCLES-2.
  - In BUSY, the counter decrements each cycle. BUSY -> DONE when the counter reaches 0.
  - In BUSY: stall_if, stall_id and stall_ex are all 1, div_busy=1, and flush_ex=0.
  - During BUSY the MEM slot receives bubbles; WB drains normally.
  - DONE lasts one cycle: div_done=1 and stalls are 0, so the div advances to MEM. Then DONE -> IDLE.
  - Total freeze is DIV_CYCLES-1 cycles; div_done is asserted on cycle DIV_CYCLES after EX entry.
- Simultaneous events
  - BUSY dominates a load-use hazard. Load-use is evaluated only in IDLE and DONE.
  - A div in ID behind a div in DONE enters EX normally and restarts BUSY.
- Reset mid-operation: the FSM returns to IDLE immediately (asynchronously). All stalls, div_busy and div_done drop in the same cycle, and the selects go to 2'b00.

Decomposition:
- Package pipe_pkg holds:
  - Forward codes: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The div FSM state enum.
  - The slot record typedef.
- One natural sub-module: div_stall_fsm, containing the counter and the IDLE/BUSY/DONE logic. It outputs busy, done and freeze.

Test Plan:
- Back-to-back dependence: add $3 followed by sub $4,$3,$5 -> in the sub's EX cycle, fwd_a_sel=2'b10 and fwd_b_sel=2'b00.
- Gap of one: add $3, nop, or $6,$3,$3 -> fwd_a_sel=2'b01 and fwd_b_sel=2'b01.
- Same-register priority: two writes to $3 back to back, then a reader -> the reader gets 2'b10, not 2'b01.
- Register-zero guard: a write to $0 followed by a reader -> the reader gets 2'b00.
- Load-use: lw $2 then add $7,$2,$1 -> exactly one cycle of stall_if=stall_id=flush_ex=1, then fwd_a_sel=2'b01.
- Divider with DIV_CYCLES=4: a div enters EX -> div_busy=1 and stall_ex=1 for 3 cycles, then div_done=1 for 1 cycle. A lw-dependent add in ID during BUSY produces no flush_ex.
- Reset mid-BUSY: assert rst during BUSY -> div_busy=0 and all stalls=0 in the same cycle. After release, a new div runs the full count.
